// File: rtl/cordic_chan_sched.sv
`default_nettype none
// ============================================================================
// Module      : cordic_chan_sched
// Description : Time-multiplexes one shared cordic_phase core across NUM_CH
//               phase-accumulator channels and re-tags its results.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_chan_sched #(
    parameter int NUM_CH         = 4,
    parameter int PHASE_W        = 20,
    parameter int PHASE_MOD      = 524288,
    parameter int CORDIC_LATENCY = 16,
    parameter int OUT_W          = 16,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                cfg_we,
    input  logic                cfg_clr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PHASE_W-1:0]  cfg_inc,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                ovr_clr,
    output logic [PHASE_W-1:0]  cordic_arg,
    input  logic [OUT_W-1:0]    cordic_sin,
    input  logic [OUT_W-1:0]    cordic_cos,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic [OUT_W-1:0]    out_sin,
    output logic [OUT_W-1:0]    out_cos,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam logic [1:0]         c_IDLE    = 2'd0;
    localparam logic [1:0]         c_ISSUE   = 2'd1;
    localparam logic [1:0]         c_DRAIN   = 2'd2;
    localparam int                 c_LAT     = CORDIC_LATENCY;
    localparam logic [PHASE_W:0]   c_MOD     = (PHASE_W+1)'(PHASE_MOD);
    localparam logic [PHASE_W-1:0] c_INC_MAX = PHASE_W'(PHASE_MOD - 1);

    logic [1:0]         r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [PHASE_W-1:0] r_phase [NUM_CH];
    logic [PHASE_W-1:0] r_inc   [NUM_CH];
    logic [PHASE_W-1:0] r_arg;
    // Stage 0 is the issue register (aligned with r_arg); stages 1..c_LAT
    // track the core latency so stage c_LAT lines up with the core result.
    logic [c_LAT:0]     r_tag_vld;
    logic [CH_W-1:0]    r_tag_ch [c_LAT+1];
    logic               r_out_valid;
    logic [CH_W-1:0]    r_out_ch;
    logic [OUT_W-1:0]   r_out_sin;
    logic [OUT_W-1:0]   r_out_cos;
    logic               r_done;
    logic               r_overrun;

    logic [CH_W-1:0]    w_sel;
    logic [NUM_CH-1:0]  w_mask_rest;
    logic               w_issue;
    logic [PHASE_W:0]   w_sum;
    logic [PHASE_W:0]   w_wrapped;
    logic [PHASE_W-1:0] w_inc_sat;
    logic               w_cfg_hit;
    logic               w_last_tag;

    // Lowest set bit of the remaining issue mask.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_sel = CH_W'(i);
            end
        end
    end

    assign w_mask_rest = r_mask & ~(NUM_CH'(1) << w_sel);
    assign w_issue     = (r_state == c_ISSUE);
    assign w_sum       = {1'b0, r_phase[w_sel]} + {1'b0, r_inc[w_sel]};
    assign w_wrapped   = (w_sum >= c_MOD) ? (w_sum - c_MOD) : w_sum;
    assign w_inc_sat   = ({1'b0, cfg_inc} >= c_MOD) ? c_INC_MAX : cfg_inc;
    assign w_cfg_hit   = (int'(cfg_ch) < NUM_CH);
    assign w_last_tag  = r_tag_vld[c_LAT] && (r_tag_vld[c_LAT-1:0] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_mask      <= '0;
            r_arg       <= '0;
            r_tag_vld   <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_sin   <= '0;
            r_out_cos   <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_phase[i] <= '0;
                r_inc[i]   <= '0;
            end
            for (int i = 0; i <= c_LAT; i++) begin
                r_tag_ch[i] <= '0;
            end
        end else begin
            r_done <= (r_state == c_DRAIN) && w_last_tag;

            case (r_state)
                c_IDLE: begin
                    if (sample_tick) begin
                        r_mask <= ch_en;
                        if (ch_en == '0) begin
                            r_done  <= 1'b1;
                            r_state <= c_DRAIN;
                        end else begin
                            r_state <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    r_mask <= w_mask_rest;
                    if (w_mask_rest == '0) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (r_tag_vld == '0) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (sample_tick && (r_state != c_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end

            // Clear is written after the issue update so it takes priority.
            if (w_issue) begin
                r_arg          <= r_phase[w_sel];
                r_phase[w_sel] <= w_wrapped[PHASE_W-1:0];
            end
            if (cfg_clr && w_cfg_hit) begin
                r_phase[cfg_ch] <= '0;
            end
            if (cfg_we && w_cfg_hit) begin
                r_inc[cfg_ch] <= w_inc_sat;
            end

            r_tag_vld   <= {r_tag_vld[c_LAT-1:0], w_issue};
            r_tag_ch[0] <= w_sel;
            for (int i = 1; i <= c_LAT; i++) begin
                r_tag_ch[i] <= r_tag_ch[i-1];
            end

            r_out_valid <= r_tag_vld[c_LAT];
            if (r_tag_vld[c_LAT]) begin
                r_out_ch  <= r_tag_ch[c_LAT];
                r_out_sin <= cordic_sin;
                r_out_cos <= cordic_cos;
            end
        end
    end

    assign cordic_arg = r_arg;
    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_sin    = r_out_sin;
    assign out_cos    = r_out_cos;
    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cordic_chan_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_chan_sched
// Description : Scoreboard bench for cordic_chan_sched with a delay-line core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_chan_sched;

    localparam int NUM_CH = 4;
    localparam int PW     = 20;
    localparam int MOD    = 524288;
    localparam int LAT    = 16;
    localparam int OW     = 16;
    localparam logic [PW:0] MODV = (PW+1)'(MOD);

    logic          clk = 1'b0;
    logic          rst, sample_tick, cfg_we, cfg_clr, ovr_clr;
    logic [1:0]    cfg_ch;
    logic [PW-1:0] cfg_inc;
    logic [3:0]    ch_en;
    logic [PW-1:0] cordic_arg;
    logic [OW-1:0] cordic_sin, cordic_cos;
    logic          out_valid;
    logic [1:0]    out_ch;
    logic [OW-1:0] out_sin, out_cos;
    logic          busy, done, overrun;

    always #5 clk = ~clk;

    cordic_chan_sched #(
        .NUM_CH(NUM_CH), .PHASE_W(PW), .PHASE_MOD(MOD),
        .CORDIC_LATENCY(LAT), .OUT_W(OW)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .ch_en(ch_en), .ovr_clr(ovr_clr), .cordic_arg(cordic_arg),
        .cordic_sin(cordic_sin), .cordic_cos(cordic_cos),
        .out_valid(out_valid), .out_ch(out_ch), .out_sin(out_sin), .out_cos(out_cos),
        .busy(busy), .done(done), .overrun(overrun)
    );

    // Core stand-in: result after edge n+LAT reflects cordic_arg after edge n.
    logic [PW-1:0] hist [LAT];
    initial for (int i = 0; i < LAT; i++) hist[i] = '0;
    always @(posedge clk) begin
        hist[0] <= cordic_arg;
        for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
    assign cordic_sin = hist[LAT-1][OW-1:0];
    assign cordic_cos = ~hist[LAT-1][OW-1:0];

    typedef struct packed {
        logic [1:0]    ch;
        logic [PW-1:0] ph;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            exp_t e;
            logic [OW-1:0] ec;
            if (sb.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                e  = sb.pop_front();
                ec = ~e.ph[OW-1:0];
                check("out_ch", out_ch, e.ch);
                check("out_sin", out_sin, e.ph[OW-1:0]);
                check("out_cos", out_cos, ec);
            end
        end
    end

    logic [PW-1:0] m_ph  [NUM_CH];
    logic [PW-1:0] m_inc [NUM_CH];
    logic [PW-1:0] exp_arg [NUM_CH];
    int n;
    int exp_cnt;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input logic [PW-1:0] i);
        logic [PW:0] s;
        s = {1'b0, p} + {1'b0, i};
        if (s >= MODV) s = s - MODV;
        return s[PW-1:0];
    endfunction

    task automatic cfg_write(input int ch, input logic [PW-1:0] inc);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch[1:0]; cfg_inc = inc;
        @(negedge clk);
        cfg_we = 1'b0;
        m_inc[ch] = ({1'b0, inc} >= MODV) ? PW'(MOD - 1) : inc;
    endtask

    task automatic cfg_clear(input int ch);
        @(negedge clk);
        cfg_clr = 1'b1; cfg_ch = ch[1:0];
        @(negedge clk);
        cfg_clr = 1'b0;
        m_ph[ch] = '0;
    endtask

    task automatic start_tick(input logic [3:0] mask);
        exp_t e;
        exp_cnt = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c]) begin
                exp_arg[exp_cnt] = m_ph[c];
                e.ch = c[1:0];
                e.ph = m_ph[c];
                sb.push_back(e);
                m_ph[c] = wrap(m_ph[c], m_inc[c]);
                exp_cnt++;
            end
        end
        @(negedge clk);
        sample_tick = 1'b1; ch_en = mask;
        @(negedge clk);
        sample_tick = 1'b0;
        n = 0;
        check("busy after tick", busy, 1);
    endtask

    // n counts edges after the tick edge; clr_at/tick_at drive inputs sampled at edge n+1.
    task automatic finish(input int exp_first, input int exp_done,
                          input int clr_at, input int clr_ch, input int tick_at);
        int first;
        int dn;
        first = -1;
        dn    = -1;
        if (done) dn = 0;
        while (dn < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (n <= exp_cnt) check("cordic_arg", cordic_arg, exp_arg[n-1]);
            if (out_valid && first < 0) first = n;
            if (tick_at >= 0 && n == tick_at + 1) check("overrun set", overrun, 1);
            if (done) begin
                dn = n;
                if (exp_cnt > 0) check("out_valid with done", out_valid, 1);
            end
            cfg_clr = (n == clr_at);
            if (n == clr_at) begin
                cfg_ch = clr_ch[1:0];
                m_ph[clr_ch] = '0;
            end
            sample_tick = (n == tick_at);
        end
        check("first valid edge", first, exp_first);
        check("done edge", dn, exp_done);
        @(negedge clk);
        n++;
        cfg_clr = 1'b0; sample_tick = 1'b0;
        check("busy dropped", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vcnt;
        rst = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_clr = 1'b0; ovr_clr = 1'b0;
        cfg_ch = '0; cfg_inc = '0; ch_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin m_ph[i] = '0; m_inc[i] = '0; end
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset overrun", overrun, 0);
        check("reset cordic_arg", cordic_arg, 0);
        check("reset out_sin", out_sin, 0);
        check("reset out_cos", out_cos, 0);
        check("reset out_ch", out_ch, 0);
        rst = 1'b0;

        // Single channel: arg 0 then 1000; result/done 18 edges after tick.
        cfg_write(0, 20'd1000);
        start_tick(4'b0001); finish(18, 18, -1, 0, -1);
        start_tick(4'b0001); finish(18, 18, -1, 0, -1);

        // All four channels back to back.
        for (int c = 0; c < NUM_CH; c++) cfg_clear(c);
        for (int c = 0; c < NUM_CH; c++) cfg_write(c, PW'(100 * (c + 1)));
        start_tick(4'b1111); finish(18, 21, -1, 0, -1);
        start_tick(4'b1111); finish(18, 21, -1, 0, -1);

        // Sparse mask and empty mask.
        start_tick(4'b0101); finish(18, 19, -1, 0, -1);
        start_tick(4'b0000); finish(-1, 0, -1, 0, -1);

        // Tick during drain is ignored and flags overrun.
        start_tick(4'b1111); finish(18, 21, -1, 0, 10);
        check("overrun sticky", overrun, 1);
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        check("overrun cleared", overrun, 0);

        // Clear of channel 1 in its own issue cycle.
        start_tick(4'b1111); finish(18, 21, 1, 1, -1);
        start_tick(4'b1111); finish(18, 21, -1, 0, -1);

        // Modulus wrap: 524000 + 524000 -> 523712.
        cfg_clear(0);
        cfg_write(0, 20'd524000);
        start_tick(4'b0001); finish(18, 18, -1, 0, -1);
        start_tick(4'b0001); finish(18, 18, -1, 0, -1);
        start_tick(4'b0001); finish(18, 18, -1, 0, -1);
        check("wrap value", exp_arg[0], 523712);

        // Oversized increment saturates to 524287.
        cfg_clear(0);
        cfg_write(0, 20'd600000);
        start_tick(4'b0001); finish(18, 18, -1, 0, -1);
        start_tick(4'b0001); finish(18, 18, -1, 0, -1);
        check("saturated inc", exp_arg[0], 524287);

        // Reset in the middle of a sequence discards in-flight tags.
        start_tick(4'b1111);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < NUM_CH; i++) begin m_ph[i] = '0; m_inc[i] = '0; end
        check("busy after reset", busy, 0);
        vcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("valids after reset", vcnt, 0);
        for (int c = 0; c < NUM_CH; c++) cfg_write(c, PW'(5 + c));
        start_tick(4'b1111); finish(18, 21, -1, 0, -1);
        check("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
